// File: rtl/fmap_collector.sv
// Frame sink: captures one CO x OUT_H x OUT_W frame, then replays it channel-major over valid/ready.
// Optional FMAP_COLLECTOR_RELU_EN clamps negative channel values to zero on write.
module fmap_collector #(
    parameter int unsigned CO     = 3,
    parameter int unsigned O_F_BW = 20,
    parameter int unsigned OUT_W  = 24,
    parameter int unsigned OUT_H  = 24,
    localparam int unsigned CH_W  = (CO > 1) ? $clog2(CO) : 1,
    localparam int unsigned Y_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int unsigned X_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_in_valid,
    input  logic [CO*O_F_BW-1:0] i_in_fmap,
    output logic                 o_frame_done,
    output logic                 o_drop,
    output logic                 o_busy,
    input  logic                 i_rd_start,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [O_F_BW-1:0]    o_rd_data,
    output logic [CH_W-1:0]      o_rd_ch,
    output logic [Y_W-1:0]       o_rd_y,
    output logic [X_W-1:0]       o_rd_x,
    output logic                 o_rd_last
);

    localparam int unsigned DEPTH = OUT_W * OUT_H;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        StCapture,
        StFull,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [X_W-1:0]  wr_x_q;
    logic [Y_W-1:0]  wr_y_q;
    logic [CH_W-1:0] rd_ch_q;
    logic [Y_W-1:0]  rd_y_q;
    logic [X_W-1:0]  rd_x_q;

    logic            issue_q;
    logic            valid_q;
    logic            last_q;
    logic [CH_W-1:0] out_ch_q;
    logic [Y_W-1:0]  out_y_q;
    logic [X_W-1:0]  out_x_q;
    logic            drop_q;
    logic            done_q;

    logic              wr_en;
    logic              wr_last_x;
    logic              wr_last_pix;
    logic              rd_last_x;
    logic              rd_last_y;
    logic              rd_final;
    logic              rd_start;
    logic              rd_hs;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [O_F_BW-1:0] wdata   [CO];
    logic [O_F_BW-1:0] bank_rd [CO];
    logic [O_F_BW-1:0] rd_data;

    assign wr_en       = (state_q == StCapture) && i_in_valid;
    assign wr_last_x   = (wr_x_q == X_W'(OUT_W - 1));
    assign wr_last_pix = wr_last_x && (wr_y_q == Y_W'(OUT_H - 1));
    assign rd_last_x   = (rd_x_q == X_W'(OUT_W - 1));
    assign rd_last_y   = (rd_y_q == Y_W'(OUT_H - 1));
    assign rd_final    = rd_last_x && rd_last_y && (rd_ch_q == CH_W'(CO - 1));
    assign rd_start    = (state_q == StFull) && i_rd_start;
    assign rd_hs       = valid_q && i_rd_ready;
    assign wr_addr     = AW'(wr_y_q) * AW'(OUT_W) + AW'(wr_x_q);
    assign rd_addr     = AW'(rd_y_q) * AW'(OUT_W) + AW'(rd_x_q);

    always_comb begin
        for (int c = 0; c < int'(CO); c++) begin
`ifdef FMAP_COLLECTOR_RELU_EN
            wdata[c] = i_in_fmap[c*O_F_BW + O_F_BW - 1] ? '0 : i_in_fmap[c*O_F_BW +: O_F_BW];
`else
            wdata[c] = i_in_fmap[c*O_F_BW +: O_F_BW];
`endif
        end
    end

    // One RAM per channel; only the bank of the channel being drained is read.
    for (genvar c = 0; c < CO; c++) begin : g_bank
        logic [O_F_BW-1:0] mem [DEPTH];
        logic [O_F_BW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_addr] <= wdata[c];
            end
            if (issue_q && (rd_ch_q == CH_W'(c))) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign bank_rd[c] = rd_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCapture;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StCapture: if (wr_en && wr_last_pix) state_d = StFull;
            StFull:    if (i_rd_start) state_d = StDrain;
            StDrain:   if (rd_hs && last_q) state_d = StCapture;
            default:   state_d = StCapture;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_x_q   <= '0;
            wr_y_q   <= '0;
            rd_ch_q  <= '0;
            rd_y_q   <= '0;
            rd_x_q   <= '0;
            issue_q  <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            out_ch_q <= '0;
            out_y_q  <= '0;
            out_x_q  <= '0;
            drop_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= wr_en && wr_last_pix;
            drop_q <= i_in_valid && (state_q != StCapture);

            if (wr_en) begin
                if (wr_last_x) begin
                    wr_x_q <= '0;
                    wr_y_q <= wr_last_pix ? '0 : wr_y_q + Y_W'(1);
                end else begin
                    wr_x_q <= wr_x_q + X_W'(1);
                end
            end

            if (rd_start) begin
                rd_ch_q <= '0;
                rd_y_q  <= '0;
                rd_x_q  <= '0;
                issue_q <= 1'b1;
            end

            // RAM data lands this edge; capture its coordinates alongside.
            if (issue_q) begin
                issue_q  <= 1'b0;
                valid_q  <= 1'b1;
                out_ch_q <= rd_ch_q;
                out_y_q  <= rd_y_q;
                out_x_q  <= rd_x_q;
                last_q   <= rd_final;
            end

            if (rd_hs) begin
                valid_q <= 1'b0;
                if (last_q) begin
                    last_q <= 1'b0;
                    wr_x_q <= '0;
                    wr_y_q <= '0;
                end else begin
                    issue_q <= 1'b1;
                    if (rd_last_x) begin
                        rd_x_q <= '0;
                        if (rd_last_y) begin
                            rd_y_q  <= '0;
                            rd_ch_q <= rd_ch_q + CH_W'(1);
                        end else begin
                            rd_y_q <= rd_y_q + Y_W'(1);
                        end
                    end else begin
                        rd_x_q <= rd_x_q + X_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (valid_q) begin
            for (int c = 0; c < int'(CO); c++) begin
                if (out_ch_q == CH_W'(c)) rd_data = bank_rd[c];
            end
        end
    end

    assign o_frame_done = done_q;
    assign o_drop       = drop_q;
    assign o_busy       = (state_q != StCapture);
    assign o_rd_valid   = valid_q;
    assign o_rd_data    = rd_data;
    assign o_rd_ch      = out_ch_q;
    assign o_rd_y       = out_y_q;
    assign o_rd_x       = out_x_q;
    assign o_rd_last    = last_q;

endmodule
